// File: rtl/ir_camera_responder_if.sv
// ir_camera_if: I2C pad signals, blob inputs and register-write outputs of the IR camera responder.
interface ir_camera_if;
    logic       i2c_scl;
    logic       i2c_sda_in;
    logic       i2c_sda;
    logic       i2c_sda_dir;
    logic [9:0] blob_x;
    logic [9:0] blob_y;
    logic [3:0] blob_size;
    logic       blob_valid;
    logic [7:0] cfg_reg30;
    logic [7:0] cfg_reg33;
    logic       reg_wr_valid;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;

    modport master (
        output i2c_scl, i2c_sda_in, blob_x, blob_y, blob_size, blob_valid,
        input  i2c_sda, i2c_sda_dir, cfg_reg30, cfg_reg33, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
    );
    modport slave (
        input  i2c_scl, i2c_sda_in, blob_x, blob_y, blob_size, blob_valid,
        output i2c_sda, i2c_sda_dir, cfg_reg30, cfg_reg33, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
    );
endinterface

// File: rtl/ir_camera_responder.sv
// ir_camera_responder: I2C target at 0x58 emulating the PixArt IR camera register file and blob report.
module ir_camera_responder #(
    parameter logic [6:0] I2C_ADDR   = 7'h58,
    parameter logic [7:0] REPORT_PTR = 8'h36
) (
    input  logic clk,
    input  logic reset,
    ir_camera_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;

    state_t     state_q;
    logic [2:0] scl_q, sda_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q, tx_q, ptr_q, cfg30_q, cfg33_q, wr_addr_q, wr_data_q;
    logic       dir_q, busy_q, first_q, rw_q, wr_valid_q;
    logic [9:0] snap_x_q, snap_y_q;
    logic [3:0] snap_s_q;
    logic       snap_v_q;

    function automatic logic [7:0] rd_byte(input logic [7:0] p, input logic [9:0] x, input logic [9:0] y,
                                           input logic [3:0] s, input logic v, input logic [7:0] c30,
                                           input logic [7:0] c33);
        logic [7:0] o;
        o = p - REPORT_PTR;
        rd_byte = o > 8'd15 ? (p == 8'h30 ? c30 : p == 8'h33 ? c33 : 8'h00) :
                  o == 8'd0 ? 8'h00 : o > 8'd12 ? 8'h00 : o > 8'd3 ? 8'hFF : !v ? 8'hFF :
                  o == 8'd1 ? x[7:0] : o == 8'd2 ? y[7:0] : {y[9:8], x[9:8], s};
    endfunction

    // [1] is the synchronized sample, [2] the previous one
    logic scl_rise, scl_fall, start, stop;
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

    logic [7:0] live_byte, cur_byte;
    assign live_byte = rd_byte(ptr_q, bus.blob_x, bus.blob_y, bus.blob_size, bus.blob_valid, cfg30_q, cfg33_q);
    assign cur_byte  = cnt_q == 4'd0 ? rd_byte(ptr_q, snap_x_q, snap_y_q, snap_s_q, snap_v_q, cfg30_q, cfg33_q) : tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], bus.i2c_scl};
            sda_q <= {sda_q[1:0], bus.i2c_sda_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            cfg30_q    <= '0;
            cfg33_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            first_q    <= 1'b0;
            rw_q       <= 1'b0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_s_q   <= '0;
            snap_v_q   <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start) begin
                state_q <= ADDR;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
            end else if (stop) begin
                state_q <= IDLE;
                dir_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, WR_BYTE: begin
                        if (scl_rise && cnt_q < 4'd8) begin
                            sh_q  <= {sh_q[6:0], sda_q[1]};
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            if (state_q == WR_BYTE) begin
                                state_q <= WR_ACK;
                                dir_q   <= 1'b1;
                                first_q <= 1'b0;
                                if (first_q) ptr_q <= sh_q;
                                else begin
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= ptr_q;
                                    wr_data_q  <= sh_q;
                                    ptr_q      <= ptr_q + 8'd1;
                                    if (ptr_q == 8'h30) cfg30_q <= sh_q;
                                    if (ptr_q == 8'h33) cfg33_q <= sh_q;
                                end
                            end else if (sh_q[7:1] == I2C_ADDR) begin
                                state_q <= ADDR_ACK;
                                dir_q   <= 1'b1;
                                busy_q  <= 1'b1;
                                rw_q    <= sh_q[0];
                            end else begin
                                state_q <= IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        // A read releases the ACK and drives bit 7 of the first byte in one step
                        if (rw_q) begin
                            state_q  <= RD_BYTE;
                            snap_x_q <= bus.blob_x;
                            snap_y_q <= bus.blob_y;
                            snap_s_q <= bus.blob_size;
                            snap_v_q <= bus.blob_valid;
                            dir_q    <= ~live_byte[7];
                            tx_q     <= {live_byte[6:0], 1'b0};
                            cnt_q    <= 4'd1;
                        end else begin
                            state_q <= WR_BYTE;
                            dir_q   <= 1'b0;
                            first_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        state_q <= WR_BYTE;
                        dir_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                    RD_BYTE: if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_q <= RD_ACK;
                            dir_q   <= 1'b0;
                            ptr_q   <= ptr_q + 8'd1;
                        end else begin
                            dir_q <= ~cur_byte[7];
                            tx_q  <= {cur_byte[6:0], 1'b0};
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        state_q <= sda_q[1] ? IGNORE : RD_BYTE;
                        cnt_q   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.i2c_sda      = 1'b0;
    assign bus.i2c_sda_dir  = dir_q;
    assign bus.cfg_reg30    = cfg30_q;
    assign bus.cfg_reg33    = cfg33_q;
    assign bus.reg_wr_valid = wr_valid_q;
    assign bus.reg_wr_addr  = wr_addr_q;
    assign bus.reg_wr_data  = wr_data_q;
    assign bus.busy         = busy_q;
endmodule
